// File: rtl/fir_filter_time_mux.sv
// Time-multiplexed FIR: one multiplier and one accumulator adder walk the taps one per cycle.
// Define FIR_OUTPUT_SATURATE_EN to clip the result to OUT_W and flag Overflow; otherwise the result wraps.
`default_nettype none

module fir_filter_time_mux #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 10,
  parameter int OUT_W  = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic signed [DATA_W-1:0] InputData,
  input  logic                     InputValid,
  output logic                     InputReady,
  input  logic [$clog2(TAPS)-1:0]  CoefficientIndex,
  input  logic signed [COEF_W-1:0] NewCoefficientValue,
  input  logic                     CoefficientWriteEnable,
  output logic signed [OUT_W-1:0]  FilteredOutput,
  output logic                     OutputValid,
  output logic                     Overflow
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);

`ifdef FIR_OUTPUT_SATURATE_EN
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  typedef enum logic {
    IDLE,
    MAC
  } state_t;

  // Returns {overflow, result} for a full-precision accumulator sum.
  function automatic logic [OUT_W:0] convert(input logic signed [ACC_W-1:0] s);
`ifdef FIR_OUTPUT_SATURATE_EN
    logic signed [EXT_W-1:0] e;
    e = EXT_W'(s);
    if (e > SAT_MAX) return {1'b1, SAT_MAX[OUT_W-1:0]};
    if (e < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
    return {1'b0, e[OUT_W-1:0]};
`else
    return {1'b0, OUT_W'(s)};
`endif
  endfunction

  state_t                     state_q;
  logic [IDX_W-1:0]           cnt_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [DATA_W-1:0]   x_q [TAPS];
  logic signed [COEF_W-1:0]   c_q [TAPS];
  logic signed [OUT_W-1:0]    out_q;
  logic                       vld_q;
  logic                       ovf_q;

  logic signed [PROD_W-1:0]   xa_d;
  logic signed [PROD_W-1:0]   ca_d;
  logic signed [PROD_W-1:0]   prod_d;
  logic signed [ACC_W-1:0]    sum_d;
  logic [OUT_W:0]             conv_d;
  logic                       wr_ok_d;

  // Single shared multiply-accumulate, steered by the tap counter.
  always_comb begin
    xa_d    = PROD_W'(x_q[cnt_q]);
    ca_d    = PROD_W'(c_q[cnt_q]);
    prod_d  = xa_d * ca_d;
    sum_d   = acc_q + ACC_W'(prod_d);
    conv_d  = convert(sum_d);
    wr_ok_d = CoefficientWriteEnable && (int'(CoefficientIndex) < TAPS);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A write landing with an accepted sample is seen by that sample's computation.
          if (wr_ok_d) c_q[CoefficientIndex] <= NewCoefficientValue;
          if (InputValid) begin
            x_q[0] <= InputData;
            for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= sum_d;
          if (cnt_q == LAST_TAP) begin
            out_q   <= conv_d[OUT_W-1:0];
            ovf_q   <= conv_d[OUT_W];
            vld_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign InputReady     = (state_q == IDLE);
  assign FilteredOutput = out_q;
  assign OutputValid    = vld_q;
  assign Overflow       = ovf_q;

endmodule

`default_nettype wire
